// File: rtl/pts_stream_serializer.sv
// Parallel-to-serial converter with a valid/ready input, a one-word holding buffer
// for gapless streaming, compile-time bit order and per-word frame flags.
module pts_stream_serializer #(
  parameter int unsigned DATA_W    = 7,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              pts_reset_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              shift,
  output logic              serial_out,
  output logic              out_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] hb_q, hb_d;
  logic              hb_full_q, hb_full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_adv;
  logic              out_bit;

  // Advance toward the output end, zero-filling the vacated bit
  always_comb begin
    if (LSB_FIRST) begin
      sr_adv  = sr_q >> 1;
      out_bit = sr_q[0];
    end else begin
      sr_adv  = sr_q << 1;
      out_bit = sr_q[DATA_W-1];
    end
  end

  always_ff @(posedge clk or negedge pts_reset_n) begin
    if (!pts_reset_n) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      hb_q      <= '0;
      hb_full_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      hb_q      <= hb_d;
      hb_full_q <= hb_full_d;
      cnt_q     <= cnt_d;
    end
  end

  // Accept and drain never coincide: accept needs an empty buffer, drain a full one
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    hb_d      = hb_q;
    hb_full_d = hb_full_q;
    cnt_d     = cnt_q;

    if (clear) begin
      state_d   = ST_IDLE;
      sr_d      = '0;
      hb_full_d = 1'b0;
      cnt_d     = '0;
    end else begin
      if (in_valid && !hb_full_q) begin
        hb_d      = data_in;
        hb_full_d = 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (hb_full_q) begin
            sr_d      = hb_q;
            hb_full_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift) begin
            if (cnt_q != CNT_LAST) begin
              sr_d  = sr_adv;
              cnt_d = cnt_q + CNT_W'(1);
            end else if (hb_full_q) begin
              sr_d      = hb_q;
              hb_full_d = 1'b0;
              cnt_d     = '0;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode, purely from registered state
  always_comb begin
    in_ready    = !hb_full_q;
    busy        = (state_q == ST_SHIFT) || hb_full_q;
    out_valid   = 1'b0;
    serial_out  = IDLE_BIT;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (state_q == ST_SHIFT) begin
      out_valid   = 1'b1;
      serial_out  = out_bit;
      frame_start = (cnt_q == '0);
      frame_end   = (cnt_q == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_pts_stream_serializer.sv
// Bench for pts_stream_serializer: an LSB-first and an MSB-first instance share stimulus
// and are compared every cycle against a word-queue reference model.
module tb_pts_stream_serializer;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         pts_reset_n;
  logic         clear;
  logic         in_valid;
  logic         shift;
  logic [W-1:0] data_in;

  logic l_ready, l_ser, l_ov, l_fs, l_fe, l_busy;
  logic m_ready, m_ser, m_ov, m_fs, m_fe, m_busy;

  always #5 clk = ~clk;

  pts_stream_serializer #(.DATA_W(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .pts_reset_n(pts_reset_n), .clear(clear), .data_in(data_in),
    .in_valid(in_valid), .in_ready(l_ready), .shift(shift), .serial_out(l_ser),
    .out_valid(l_ov), .frame_start(l_fs), .frame_end(l_fe), .busy(l_busy)
  );

  pts_stream_serializer #(.DATA_W(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .pts_reset_n(pts_reset_n), .clear(clear), .data_in(data_in),
    .in_valid(in_valid), .in_ready(m_ready), .shift(shift), .serial_out(m_ser),
    .out_valid(m_ov), .frame_start(m_fs), .frame_end(m_fe), .busy(m_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: word in flight, index of the bit on the wire, pending-word queue
  bit           m_active;
  logic [W-1:0] m_cur;
  int           m_idx;
  logic [W-1:0] m_pend[$];

  // Receiver side: words reassembled from each instance, plus per-test statistics
  logic [W-1:0] rx_l[$];
  logic [W-1:0] rx_m[$];
  logic [W-1:0] lw, mw;
  int lpos, mpos;
  int n_valid, n_fend, run, max_run;
  logic [W-1:0] prod_q[$];

  task automatic model_reset();
    m_active = 1'b0;
    m_idx    = 0;
    m_cur    = '0;
    m_pend.delete();
    lpos = 0;
    mpos = 0;
  endtask

  task automatic model_step(input logic sh, input logic clr, input bit acc, input logic [W-1:0] d);
    if (clr) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_pend.delete();
    end else begin
      if (!m_active) begin
        if (m_pend.size() != 0) begin
          m_cur    = m_pend.pop_front();
          m_idx    = 0;
          m_active = 1'b1;
        end
      end else if (sh) begin
        if (m_idx < int'(W) - 1) m_idx++;
        else if (m_pend.size() != 0) begin
          m_cur = m_pend.pop_front();
          m_idx = 0;
        end else begin
          m_active = 1'b0;
          m_idx    = 0;
        end
      end
      if (acc) m_pend.push_back(d);
    end
  endtask

  function automatic logic [5:0] exp_vec(input bit msb);
    logic ser;
    ser = msb ? 1'b1 : 1'b0;
    if (m_active) ser = msb ? m_cur[int'(W) - 1 - m_idx] : m_cur[m_idx];
    return {ser, m_active, m_active && (m_idx == 0), m_active && (m_idx == int'(W) - 1),
            m_pend.size() == 0, m_active || (m_pend.size() != 0)};
  endfunction

  task automatic clear_stats();
    n_valid = 0; n_fend = 0; run = 0; max_run = 0;
    rx_l.delete(); rx_m.delete();
  endtask

  // Reassemble words from the bit that will be consumed at the coming edge
  task automatic capture(input logic sh, input logic clr);
    if (!clr && sh && l_ov) begin
      if (l_fs) lpos = 0;
      lw[lpos] = l_ser;
      lpos++;
      if (l_fe) rx_l.push_back(lw);
    end
    if (!clr && sh && m_ov) begin
      if (m_fs) mpos = 0;
      mw[int'(W) - 1 - mpos] = m_ser;
      mpos++;
      if (m_fe) rx_m.push_back(mw);
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic sh, input logic clr);
    bit acc;
    in_valid = v; data_in = d; shift = sh; clear = clr;
    capture(sh, clr);
    acc = v && !clr && (m_pend.size() == 0);
    @(posedge clk);
    model_step(sh, clr, acc, d);
    @(negedge clk);
    check("lsb_outputs", 32'({l_ser, l_ov, l_fs, l_fe, l_ready, l_busy}), 32'(exp_vec(1'b0)));
    check("msb_outputs", 32'({m_ser, m_ov, m_fs, m_fe, m_ready, m_busy}), 32'(exp_vec(1'b1)));
    if (l_ov) begin
      n_valid++; run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (l_fe) n_fend++;
  endtask

  // Producer holding each word on data_in until it is taken; shift held high
  task automatic stream(input int ncyc, input logic [W-1:0] watch, output bit watch_blocked);
    bit v, seen;
    logic [W-1:0] d;
    seen = 1'b0;
    watch_blocked = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      v = prod_q.size() != 0;
      d = v ? prod_q[0] : '0;
      if (v && d == watch && !seen) begin
        seen = 1'b1;
        watch_blocked = !l_ready && !m_ready;
      end
      if (v && m_pend.size() == 0) void'(prod_q.pop_front());
      cycle(v, d, 1'b1, 1'b0);
    end
  endtask

  initial begin
    bit blocked;
    pts_reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; shift = 1'b0; data_in = '0;
    model_reset();
    clear_stats();
    #12;
    check("reset_lsb", 32'({l_ser, l_ov, l_fs, l_fe, l_ready, l_busy}), 32'(6'b000010));
    check("reset_msb", 32'({m_ser, m_ov, m_fs, m_fe, m_ready, m_busy}), 32'(6'b100010));
    @(negedge clk);
    pts_reset_n = 1'b1;

    // Single word, shift held high
    clear_stats();
    cycle(1'b1, 7'b1011001, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("single_len", 32'(n_valid), 32'd7);
    check("single_nwords", 32'(rx_l.size()), 32'd1);
    if (rx_l.size() == 1) check("single_lsb_word", 32'(rx_l[0]), 32'h59);
    if (rx_m.size() == 1) check("single_msb_word", 32'(rx_m[0]), 32'h59);
    check("single_idle", 32'({l_ser, m_ser, l_busy}), 32'(3'b010));

    // Back-to-back, gapless
    clear_stats();
    prod_q = '{7'h55, 7'h2A};
    stream(25, 7'h00, blocked);
    check("b2b_run", 32'(max_run), 32'd14);
    check("b2b_nwords", 32'(rx_l.size()), 32'd2);
    if (rx_l.size() == 2) begin
      check("b2b_w0", 32'(rx_l[0]), 32'h55);
      check("b2b_w1", 32'(rx_l[1]), 32'h2A);
    end

    // Rate gating: one shift tick in three
    clear_stats();
    for (int c = 0; c < 30; c++) cycle(c == 0, 7'h7F, (c % 3) == 1, 1'b0);
    check("rate_valid_cycles", 32'(n_valid), 32'd21);
    check("rate_fend_cycles", 32'(n_fend), 32'd3);

    // Backpressure: third word waits for the buffer to drain
    clear_stats();
    prod_q = '{7'h33, 7'h44, 7'h11};
    stream(35, 7'h11, blocked);
    check("bp_ready_low", 32'(blocked), 32'd1);
    check("bp_nwords", 32'(rx_l.size()), 32'd3);
    if (rx_l.size() == 3) check("bp_third", 32'(rx_l[2]), 32'h11);
    if (rx_m.size() == 3) check("bp_third_msb", 32'(rx_m[2]), 32'h11);

    // Asynchronous reset mid-frame
    clear_stats();
    cycle(1'b1, 7'h6B, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    #2 pts_reset_n = 1'b0;
    #1;
    check("rst_mid_lsb", 32'({l_ser, l_ov, l_fs, l_fe, l_ready, l_busy}), 32'(6'b000010));
    check("rst_mid_msb", 32'({m_ser, m_ov, m_fs, m_fe, m_ready, m_busy}), 32'(6'b100010));
    model_reset();
    @(negedge clk);
    pts_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("rst_no_frame_end", 32'(rx_l.size()), 32'd0);

    // Clear with a concurrent offer drops everything
    clear_stats();
    cycle(1'b1, 7'h12, 1'b1, 1'b0);
    cycle(1'b1, 7'h34, 1'b1, 1'b0);
    cycle(1'b1, 7'h56, 1'b1, 1'b1);
    check("clear_busy", 32'({l_busy, m_busy}), 32'd0);
    n_valid = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("clear_silent", 32'(n_valid), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(1)), W'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pts_stream_serializer.md
Name: pts_stream_serializer

Overview:
- Parametrised parallel-to-serial converter that succeeds the fixed 4-bit shifter. Typical use is serialising Hamming codewords, e.g. 7-bit (7,4) words, onto a single-bit channel.
- Adds a valid/ready input handshake, a one-word holding buffer so back-to-back words stream with no gap, selectable bit order, and frame-boundary flags.
- Sits between the Hamming encoder output and the serial link / channel model.

Parameters:
- DATA_W, 7, word width in bits; legal range ≥2.
- LSB_FIRST, 1, 1 = bit 0 is transmitted first; 0 = bit DATA_W-1 is transmitted first.
- IDLE_BIT, 0, value driven on serial_out when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- pts_reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; empties the shift register and holding buffer.
- data_in  input  DATA_W  parallel word.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  holding buffer can accept a word.
- shift  input  1  bit-rate enable; advances one bit per clk in which it is high.
- serial_out  output  1  current serial bit.
- out_valid  output  1  serial_out carries a word bit.
- frame_start  output  1  current bit is bit-index 0 of a word.
- frame_end  output  1  current bit is the last bit of a word.
- busy  output  1  shifting in progress or holding buffer full.

Behaviour:
- Interface: one clock (clk); reset pts_reset_n is asynchronous and active-low.
- State:
  - SR[DATA_W-1:0] shift register.
  - HB[DATA_W-1:0] holding buffer plus hb_full flag.
  - cnt, width clog2(DATA_W), counts bits already sent.
  - FSM with states IDLE and SHIFT.
- Reset (asynchronous assert, synchronous release): SR=0, HB=0, hb_full=0, cnt=0, state=IDLE.
  - Outputs during/after reset: serial_out=IDLE_BIT, out_valid=0, in_ready=1, frame_start=0, frame_end=0, busy=0.
- Accept:
  - in_ready = !hb_full, combinational from registers only.
  - A word is accepted on a clk edge with in_valid && in_ready: HB<=data_in, hb_full<=1.
  - in_valid while in_ready=0 is ignored; the producer must hold the word.
- IDLE:
  - If hb_full at an edge: SR<=HB, hb_full<=0, cnt<=0, go SHIFT.
  - This load does not wait for shift.
  - Latency from acceptance to first bit on serial_out is 2 clk edges.
- SHIFT:
  - serial_out = SR[0] (LSB_FIRST=1) or SR[DATA_W-1] (LSB_FIRST=0).
  - out_valid=1, frame_start=(cnt==0), frame_end=(cnt==DATA_W-1); all combinational from registers.
  - When shift=0: hold everything.
  - When shift=1 and cnt<DATA_W-1: shift SR one place toward the output end, zero-filling the vacated bit; cnt<=cnt+1.
  - When shift=1 and cnt==DATA_W-1:
    - If hb_full: SR<=HB, hb_full<=0, cnt<=0, stay in SHIFT. This gives gapless streaming.
    - Otherwise: go IDLE, cnt<=0.
- Simultaneous accept and drain in one cycle cannot occur, because in_ready=0 whenever HB is being drained.
  - in_ready rises the cycle after the drain.
  - Streaming stays gapless provided the producer presents the next word within DATA_W-1 shift ticks.
- busy = (state==SHIFT) || hb_full.
- clear (synchronous) takes priority over accept, load and shift in the same cycle.
  - Result: state=IDLE, hb_full=0, cnt=0, SR=0.
  - A concurrent in_valid is dropped.
- Reset mid-frame aborts immediately; the partial word is lost and no frame_end is produced.
- Bit order within a word is fixed by LSB_FIRST. There is no runtime mode port.

Test Plan:
- Single word (DATA_W=7, LSB_FIRST=1, shift held 1): accept 7'b1011001 → after 2 edges serial_out = 1,0,0,1,1,0,1 with out_valid=1 for exactly 7 cycles; frame_start on bit 1, frame_end on bit 7; then serial_out=IDLE_BIT and busy=0.
- MSB-first (LSB_FIRST=0): accept 7'b1011001 → serial_out = 1,0,1,1,0,0,1.
- Back-to-back: with shift=1, offer 7'h55 then 7'h2A with in_valid held → 14 consecutive out_valid cycles with no IDLE bit between words; in_ready=0 while HB is full and rises the cycle after the second load.
- Rate gating: shift pulsed one cycle in three with word 7'h7F → each bit is held 3 clk cycles; frame_end lasts until the 7th tick; total 21 cycles in SHIFT.
- Backpressure: with SR shifting and HB full, assert in_valid with 7'h11 → in_ready=0 and HB unchanged; 7'h11 is accepted only after the drain and is transmitted third.
- Reset/clear: assert pts_reset_n=0 at bit 3 → serial_out=IDLE_BIT, out_valid=0, in_ready=1 immediately. Separately, clear asserted together with in_valid → word dropped, busy=0 next cycle.
